// File: rtl/hazard_ctrl_pkg.sv
// Shared types and defaults for the pipeline hazard controller.
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_MDU_BUSY = 2'd1,
        S_EXC_WAIT = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_e;

    typedef struct packed {
        logic f;
        logic d;
        logic e;
        logic m;
        logic w;
    } stage_t;

    localparam logic [31:0] EXC_VEC_DEFAULT  = 32'hBFC00380;
    localparam logic [31:0] ERET_EXC_DEFAULT = 32'h0000000E;

    // A latency of L needs to hold values L-1 down to 0.
    function automatic int cnt_width(input int lat);
        return (lat > 1) ? $clog2(lat) : 1;
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Datapath <-> hazard controller signal bundle.
interface hazard_ctrl_if #(
    parameter int RW = 5,
    parameter int AW = 32
);
    logic [RW-1:0] rsD, rtD;
    logic          branchD, jrD;
    logic [RW-1:0] rsE, rtE, writeregE;
    logic          regwriteE, memtoregE, mdu_startE;
    logic [RW-1:0] writeregM;
    logic          regwriteM, memtoregM;
    logic [AW-1:0] excepttypeM, epcM;
    logic [RW-1:0] writeregW;
    logic          regwriteW;
    logic          i_stall, d_stall;

    logic          stallF, stallD, stallE, stallM, stallW;
    logic          flushF, flushD, flushE, flushM, flushW;
    logic          forwardaD, forwardbD;
    logic [1:0]    forwardaE, forwardbE;
    logic [AW-1:0] newpc;
    logic          pc_redirect;
    logic          mdu_busy;

    modport master (
        output rsD, rtD, branchD, jrD, rsE, rtE, writeregE, regwriteE, memtoregE,
               mdu_startE, writeregM, regwriteM, memtoregM, excepttypeM, epcM,
               writeregW, regwriteW, i_stall, d_stall,
        input  stallF, stallD, stallE, stallM, stallW,
               flushF, flushD, flushE, flushM, flushW,
               forwardaD, forwardbD, forwardaE, forwardbE,
               newpc, pc_redirect, mdu_busy
    );

    modport slave (
        input  rsD, rtD, branchD, jrD, rsE, rtE, writeregE, regwriteE, memtoregE,
               mdu_startE, writeregM, regwriteM, memtoregM, excepttypeM, epcM,
               writeregW, regwriteW, i_stall, d_stall,
        output stallF, stallD, stallE, stallM, stallW,
               flushF, flushD, flushE, flushM, flushW,
               forwardaD, forwardbD, forwardaE, forwardbE,
               newpc, pc_redirect, mdu_busy
    );
endinterface

// File: rtl/hazard_ctrl_mdu_timer.sv
// MDU occupancy down-counter: busy for LAT cycles starting with the start cycle.
module hazard_ctrl_mdu_timer
    import hazard_ctrl_pkg::*;
#(
    parameter int LAT = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic i_start,
    input  logic i_abort,
    output logic o_busy,
    output logic o_done
);
    localparam int CW = cnt_width(LAT);

    logic [CW-1:0] r_cnt;
    logic          r_run;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_run <= 1'b0;
        end else if (i_abort) begin
            r_cnt <= '0;
            r_run <= 1'b0;
        end else if (i_start) begin
            r_cnt <= CW'(LAT - 1);
            r_run <= 1'b1;
        end else if (r_run) begin
            if (r_cnt != '0) r_cnt <= r_cnt - CW'(1);
            else             r_run <= 1'b0;
        end
    end

    // The count==0 cycle lets the held op leave E, so it is not busy.
    assign o_busy = r_run && (r_cnt != '0);
    assign o_done = r_run && (r_cnt == '0);
endmodule

// File: rtl/hazard_ctrl.sv
// Forwarding, load-use/branch stalls, MDU hold and exception redirect
// control for the 5-stage MIPS pipeline.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int            RW       = 5,
    parameter int            AW       = 32,
    parameter int            MDU_LAT  = 32,
    parameter logic [AW-1:0] EXC_VEC  = AW'(EXC_VEC_DEFAULT),
    parameter logic [AW-1:0] ERET_EXC = AW'(ERET_EXC_DEFAULT)
) (
    input  logic         clk,
    input  logic         rst,
    hazard_ctrl_if.slave hz
);
    state_e        r_state;
    logic [AW-1:0] r_exc_code, r_exc_epc, r_newpc;

    logic [RW-1:0] w_src_d [2];
    logic [RW-1:0] w_src_e [2];
    logic [1:0]    w_fwd_e [2];
    logic [1:0]    w_fwd_d, w_hit_e, w_hit_m;
    logic          w_lwstall, w_brstall;
    logic          w_exc_new, w_exc_take, w_exc_defer, w_issue;
    logic          w_tmr_busy, w_tmr_done, w_busy;
    logic [AW-1:0] w_code, w_epc, w_target;
    stage_t        w_stall, w_flush;

    assign w_src_d[0] = hz.rsD;
    assign w_src_d[1] = hz.rtD;
    assign w_src_e[0] = hz.rsE;
    assign w_src_e[1] = hz.rtE;

    for (genvar gi = 0; gi < 2; gi++) begin : g_src
        assign w_fwd_e[gi] =
            (w_src_e[gi] != '0 && hz.regwriteM && w_src_e[gi] == hz.writeregM) ? FWD_M :
            (w_src_e[gi] != '0 && hz.regwriteW && w_src_e[gi] == hz.writeregW) ? FWD_W :
                                                                                 FWD_RF;
        assign w_fwd_d[gi] = (w_src_d[gi] != '0) && hz.regwriteM && (w_src_d[gi] == hz.writeregM);
        assign w_hit_e[gi] = (hz.writeregE != '0) && (w_src_d[gi] == hz.writeregE);
        assign w_hit_m[gi] = (hz.writeregM != '0) && (w_src_d[gi] == hz.writeregM);
    end

    assign w_lwstall = hz.memtoregE && (|w_hit_e);
    assign w_brstall = (hz.branchD || hz.jrD) &&
                       ((hz.regwriteE && (|w_hit_e)) || (hz.memtoregM && (|w_hit_m)));

    // Once parked in EXC_WAIT, new M-stage exception inputs are ignored.
    assign w_exc_new   = (r_state != S_EXC_WAIT) && (hz.excepttypeM != '0);
    assign w_exc_take  = !rst && !hz.d_stall && (w_exc_new || r_state == S_EXC_WAIT);
    assign w_exc_defer = hz.d_stall && w_exc_new;
    assign w_issue     = (MDU_LAT > 0) && (r_state == S_IDLE) && hz.mdu_startE &&
                         !hz.d_stall && !w_exc_new;

    assign w_code   = (r_state == S_EXC_WAIT) ? r_exc_code : hz.excepttypeM;
    assign w_epc    = (r_state == S_EXC_WAIT) ? r_exc_epc  : hz.epcM;
    assign w_target = (w_code == ERET_EXC) ? w_epc : EXC_VEC;

    hazard_ctrl_mdu_timer #(.LAT(MDU_LAT)) u_mdu_timer (
        .clk    (clk),
        .rst    (rst),
        .i_start(w_issue),
        .i_abort(w_exc_take || w_exc_defer),
        .o_busy (w_tmr_busy),
        .o_done (w_tmr_done)
    );

    assign w_busy = w_issue || w_tmr_busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_exc_code <= '0;
            r_exc_epc  <= '0;
            r_newpc    <= '0;
        end else if (w_exc_take) begin
            r_state    <= S_IDLE;
            r_exc_code <= '0;
            r_exc_epc  <= '0;
            r_newpc    <= w_target;
        end else if (w_exc_defer) begin
            r_state    <= S_EXC_WAIT;
            r_exc_code <= hz.excepttypeM;
            r_exc_epc  <= hz.epcM;
        end else begin
            case (r_state)
                S_IDLE:     if (w_issue)    r_state <= S_MDU_BUSY;
                S_MDU_BUSY: if (w_tmr_done) r_state <= S_IDLE;
                default:                    r_state <= r_state;
            endcase
        end
    end

    always_comb begin
        w_stall = '0;
        w_flush = '0;
        if (rst) begin
            w_stall = '0;
        end else if (w_exc_take) begin
            w_flush = '1;
        end else if (r_state == S_EXC_WAIT) begin
            w_stall = '1;
        end else begin
            w_stall.w = hz.d_stall;
            w_stall.m = hz.d_stall;
            w_stall.e = hz.d_stall || w_busy;
            w_stall.d = w_stall.e || hz.i_stall || w_lwstall || w_brstall;
            w_stall.f = w_stall.d;
            w_flush.e = (w_lwstall || w_brstall || hz.i_stall) && !w_stall.e;
            w_flush.m = w_busy && !hz.d_stall;
        end
    end

    assign hz.stallF      = w_stall.f;
    assign hz.stallD      = w_stall.d;
    assign hz.stallE      = w_stall.e;
    assign hz.stallM      = w_stall.m;
    assign hz.stallW      = w_stall.w;
    assign hz.flushF      = w_flush.f;
    assign hz.flushD      = w_flush.d;
    assign hz.flushE      = w_flush.e;
    assign hz.flushM      = w_flush.m;
    assign hz.flushW      = w_flush.w;
    assign hz.forwardaE   = w_fwd_e[0];
    assign hz.forwardbE   = w_fwd_e[1];
    assign hz.forwardaD   = w_fwd_d[0];
    assign hz.forwardbD   = w_fwd_d[1];
    assign hz.pc_redirect = w_exc_take;
    assign hz.newpc       = w_exc_take ? w_target : r_newpc;
    assign hz.mdu_busy    = !rst && !w_exc_take && w_busy;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench: two hazard_ctrl instances (MDU_LAT=4 and 0) against a cycle-level model.
module tb_hazard_ctrl;
    localparam int          LAT  = 4;
    localparam logic [31:0] VEC  = 32'hBFC00380;
    localparam logic [31:0] ERET = 32'h0000000E;

    typedef struct packed {
        logic        rst;
        logic [4:0]  rsD, rtD;
        logic        branchD, jrD;
        logic [4:0]  rsE, rtE, writeregE;
        logic        regwriteE, memtoregE, mdu_startE;
        logic [4:0]  writeregM;
        logic        regwriteM, memtoregM;
        logic [31:0] excepttypeM, epcM;
        logic [4:0]  writeregW;
        logic        regwriteW, i_stall, d_stall;
    } in_t;

    typedef struct packed {
        logic [4:0]  stall;   // F D E M W
        logic [4:0]  flush;   // F D E M W
        logic [1:0]  fae, fbe;
        logic        fad, fbd;
        logic [31:0] newpc;
        logic        redir;
        logic        busy;
    } exp_t;

    typedef struct packed {
        logic [31:0] cyc;
        exp_t        e;
    } sb_t;

    logic clk = 1'b0;
    logic rst;
    in_t  x_drv;
    exp_t act_vec [2];
    sb_t  q4 [$];
    sb_t  q0 [$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;

    // Model state per instance: pending deferred exception, MDU issue time, last redirect target.
    bit          m_pend [2];
    logic [31:0] m_code [2];
    logic [31:0] m_epc  [2];
    bit          m_act  [2];
    int          m_issue[2];
    logic [31:0] m_last [2];

    always #5 clk = ~clk;
    assign rst = x_drv.rst;

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        hazard_ctrl_if #(.RW(5), .AW(32)) hz ();
        assign hz.rsD = x_drv.rsD;             assign hz.rtD = x_drv.rtD;
        assign hz.branchD = x_drv.branchD;     assign hz.jrD = x_drv.jrD;
        assign hz.rsE = x_drv.rsE;             assign hz.rtE = x_drv.rtE;
        assign hz.writeregE = x_drv.writeregE; assign hz.regwriteE = x_drv.regwriteE;
        assign hz.memtoregE = x_drv.memtoregE; assign hz.mdu_startE = x_drv.mdu_startE;
        assign hz.writeregM = x_drv.writeregM; assign hz.regwriteM = x_drv.regwriteM;
        assign hz.memtoregM = x_drv.memtoregM; assign hz.excepttypeM = x_drv.excepttypeM;
        assign hz.epcM = x_drv.epcM;           assign hz.writeregW = x_drv.writeregW;
        assign hz.regwriteW = x_drv.regwriteW; assign hz.i_stall = x_drv.i_stall;
        assign hz.d_stall = x_drv.d_stall;

        hazard_ctrl #(.RW(5), .AW(32), .MDU_LAT(gi == 0 ? LAT : 0)) u_dut (
            .clk(clk), .rst(rst), .hz(hz)
        );

        assign act_vec[gi] = {hz.stallF, hz.stallD, hz.stallE, hz.stallM, hz.stallW,
                              hz.flushF, hz.flushD, hz.flushE, hz.flushM, hz.flushW,
                              hz.forwardaE, hz.forwardbE, hz.forwardaD, hz.forwardbD,
                              hz.newpc, hz.pc_redirect, hz.mdu_busy};
    end

    function automatic logic [1:0] fwd_sel(input logic [4:0] src, input in_t x);
        if (src != 0 && x.regwriteM && src == x.writeregM) return 2'b10;
        if (src != 0 && x.regwriteW && src == x.writeregW) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bool_in(input logic [4:0] r, input in_t x);
        return (r != 0) && (r == x.rsD || r == x.rtD);
    endfunction

    // An issued MDU op holds E for lat cycles (issue cycle included), then leaves E in cycle issue+lat.
    task automatic model(input int k, input int lat, input in_t x, output exp_t e);
        logic        lw, br, busy, take, s_e, s_fd;
        bit          on, rel, issue;
        logic [31:0] code, epc;
        e     = '0;
        e.fae = fwd_sel(x.rsE, x);
        e.fbe = fwd_sel(x.rtE, x);
        e.fad = (fwd_sel(x.rsD, x) == 2'b10);
        e.fbd = (fwd_sel(x.rtD, x) == 2'b10);
        if (x.rst) begin
            m_pend[k] = 0; m_act[k] = 0; m_last[k] = '0;
            return;
        end
        on    = m_act[k] && (cyc < m_issue[k] + lat);
        rel   = m_act[k] && (cyc == m_issue[k] + lat);
        issue = (lat > 0) && !m_pend[k] && !on && !rel && x.mdu_startE && !x.d_stall
                && (x.excepttypeM == 0);
        if (issue) begin m_act[k] = 1; m_issue[k] = cyc; end
        busy = on || issue;
        take = !x.d_stall && (m_pend[k] || x.excepttypeM != 0);
        code = m_pend[k] ? m_code[k] : x.excepttypeM;
        epc  = m_pend[k] ? m_epc[k]  : x.epcM;
        if (take) begin
            e.flush   = '1;
            e.redir   = 1'b1;
            m_last[k] = (code == ERET) ? epc : VEC;
            m_pend[k] = 0;
            m_act[k]  = 0;
        end else if (m_pend[k]) begin
            e.stall = '1;
        end else begin
            lw   = x.memtoregE && bool_in(x.writeregE, x);
            br   = (x.branchD || x.jrD) && ((x.regwriteE && bool_in(x.writeregE, x)) ||
                                            (x.memtoregM && bool_in(x.writeregM, x)));
            s_e  = x.d_stall || busy;
            s_fd = s_e || x.i_stall || lw || br;
            e.stall = {s_fd, s_fd, s_e, x.d_stall, x.d_stall};
            e.flush = {2'b00, (lw || br || x.i_stall) && !s_e, busy && !x.d_stall, 1'b0};
            e.busy  = busy;
            if (x.excepttypeM != 0) begin
                m_pend[k] = 1; m_code[k] = x.excepttypeM; m_epc[k] = x.epcM; m_act[k] = 0;
            end
        end
        e.newpc = m_last[k];
        if (m_act[k] && cyc >= m_issue[k] + lat) m_act[k] = 0;
    endtask

    task automatic apply(input in_t x);
        exp_t e;
        @(posedge clk);
        #1;
        x_drv = x;
        model(0, LAT, x, e);
        q4.push_back({32'(cyc), e});
        model(1, 0, x, e);
        q0.push_back({32'(cyc), e});
        cyc++;
    endtask

    function automatic string fmt(input exp_t v);
        return $sformatf("stall=%b flush=%b fwdE=%b/%b fwdD=%b/%b newpc=%h redir=%b busy=%b",
                         v.stall, v.flush, v.fae, v.fbe, v.fad, v.fbd, v.newpc, v.redir, v.busy);
    endfunction

    task automatic check(input int k, input sb_t s);
        n_vec++;
        if (act_vec[k] !== s.e) begin
            n_err++;
            $display("FAIL %s cyc=%0d got %s | want %s", (k == 0) ? "lat4" : "lat0",
                     s.cyc, fmt(act_vec[k]), fmt(s.e));
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (q4.size() > 0) check(0, q4.pop_front());
            if (q0.size() > 0) check(1, q0.pop_front());
        end
    end

    function automatic in_t rnd();
        in_t x;
        x.rst         = ($urandom_range(0, 199) == 0);
        x.rsD         = 5'($urandom_range(0, 3));
        x.rtD         = 5'($urandom_range(0, 3));
        x.branchD     = ($urandom_range(0, 3) == 0);
        x.jrD         = ($urandom_range(0, 7) == 0);
        x.rsE         = 5'($urandom_range(0, 3));
        x.rtE         = 5'($urandom_range(0, 3));
        x.writeregE   = 5'($urandom_range(0, 3));
        x.regwriteE   = $urandom_range(0, 1) == 1;
        x.memtoregE   = ($urandom_range(0, 3) == 0);
        x.mdu_startE  = ($urandom_range(0, 5) == 0);
        x.writeregM   = 5'($urandom_range(0, 3));
        x.regwriteM   = $urandom_range(0, 1) == 1;
        x.memtoregM   = ($urandom_range(0, 3) == 0);
        case ($urandom_range(0, 19))
            0:       x.excepttypeM = 32'h1;
            1:       x.excepttypeM = 32'h8;
            2:       x.excepttypeM = ERET;
            default: x.excepttypeM = 32'h0;
        endcase
        x.epcM        = $urandom;
        x.writeregW   = 5'($urandom_range(0, 3));
        x.regwriteW   = $urandom_range(0, 1) == 1;
        x.i_stall     = ($urandom_range(0, 4) == 0);
        x.d_stall     = ($urandom_range(0, 3) == 0);
        return x;
    endfunction

    initial begin
        in_t x;
        x_drv     = '0;
        x_drv.rst = 1'b1;
        x = '0; x.rst = 1'b1;
        repeat (2) apply(x);
        x = '0;
        apply(x);
        // load-use then W-stage forward
        x = '0; x.memtoregE = 1; x.regwriteE = 1; x.writeregE = 5'd2; x.rsD = 5'd2; apply(x);
        x = '0; x.rsE = 5'd2; x.writeregW = 5'd2; x.regwriteW = 1; apply(x);
        // M forward beats W; register 0 never forwards
        x = '0; x.regwriteM = 1; x.writeregM = 5'd5; x.rsE = 5'd5; x.writeregW = 5'd5; x.regwriteW = 1;
        apply(x);
        x.rsE = 5'd0; apply(x);
        // MDU hold, op stays in E until released
        x = '0; x.mdu_startE = 1; repeat (5) apply(x);
        x = '0; repeat (2) apply(x);
        // immediate exceptions
        x = '0; x.excepttypeM = 32'h1; x.epcM = 32'h1234_5678; apply(x);
        x = '0; apply(x);
        x = '0; x.excepttypeM = ERET; x.epcM = 32'h8000_0010; apply(x);
        x = '0; apply(x);
        // deferred exceptions with M inputs changing while waiting
        x = '0; x.excepttypeM = 32'h8; x.d_stall = 1; apply(x);
        x.excepttypeM = ERET; x.epcM = 32'h8000_0040; repeat (2) apply(x);
        x.d_stall = 0; x.excepttypeM = 32'h0; apply(x);
        x = '0; x.excepttypeM = ERET; x.epcM = 32'h8000_0020; x.d_stall = 1; apply(x);
        x.excepttypeM = 32'h0; x.epcM = 32'h0; apply(x);
        x.d_stall = 0; apply(x);
        // reset mid-MDU
        x = '0; x.mdu_startE = 1; repeat (2) apply(x);
        x.rst = 1; apply(x);
        x = '0; repeat (3) apply(x);
        for (int i = 0; i < 1500; i++) apply(rnd());
        x = '0; apply(x);
        @(negedge clk);
        @(negedge clk);
        if (q4.size() != 0 || q0.size() != 0) begin
            n_err++;
            $display("FAIL drain pending=%0d/%0d want 0/0", q4.size(), q0.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
